reg_arbiter: RTL

Two-port arbiter and sequencer in front of the SD host register set. Shares the single-ported register set between the host bus interface (port H) and the SD command/data engine (port S). Grants one requester at a time round-robin, drives the register-set req/ack handshake, returns read data, and flags a timeout error if the register set never acknowledges.

---
 rtl/reg_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/reg_arbiter.sv
// Round-robin two-port arbiter in front of the single-ported SD host register set.
// Serves port H or S one at a time through a req/ack handshake with timeout.
module reg_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  h_req,
  input  logic                  h_wnr,
  input  logic [ADDR_WIDTH-1:0] h_address,
  input  logic [DATA_WIDTH-1:0] h_data_in,
  output logic                  h_ack,
  output logic                  h_err,
  output logic [DATA_WIDTH-1:0] h_data_out,
  input  logic                  s_req,
  input  logic                  s_wnr,
  input  logic [ADDR_WIDTH-1:0] s_address,
  input  logic [DATA_WIDTH-1:0] s_data_in,
  output logic                  s_ack,
  output logic                  s_err,
  output logic [DATA_WIDTH-1:0] s_data_out,
  output logic                  mem_req,
  output logic                  mem_wnr,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  busy,
  output logic                  grant
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic grant_q, grant_d;
  logic last_q, last_d;
  logic wnr_q, wnr_d;
  logic err_q, err_d;
  logic pick;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [7:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      wnr_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wnr_q   <= wnr_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // On a tie the port not served last wins.
  assign pick = (h_req && s_req) ? ~last_q : s_req;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wnr_d   = wnr_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (h_req || s_req) begin
          grant_d = pick;
          wnr_d   = pick ? s_wnr : h_wnr;
          addr_d  = pick ? s_address : h_address;
          wdata_d = pick ? s_data_in : h_data_in;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ack) begin
          rdata_d = wnr_q ? '0 : mem_data_out;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == 8'(TIMEOUT)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign h_ack       = (state_q == DONE) && !grant_q;
  assign s_ack       = (state_q == DONE) && grant_q;
  assign h_err       = h_ack && err_q;
  assign s_err       = s_ack && err_q;
  assign h_data_out  = h_ack ? rdata_q : '0;
  assign s_data_out  = s_ack ? rdata_q : '0;
  assign mem_req     = (state_q == ISSUE);
  assign mem_wnr     = wnr_q;
  assign mem_address = addr_q;
  assign mem_data_in = wdata_q;
  assign busy        = (state_q != IDLE);
  assign grant       = grant_q;

endmodule
